mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares one SRAM-like memory port between the CPU's instruction-fetch side (IF stage) and load/store side (EX/MEM stages). It sits between the pipeline and the memory bridge. It grants one requester at a time, holds a single outstanding transaction, and routes the response back to its owner. Data requests take priority over instruction requests, and a starvation guard keeps instruction fetch from being locked out.

## Interface

Parameters:
- STARVE_LIMIT, 4: number of consecutive data grants, while an instruction request is waiting, that forces the next grant to instruction.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- inst_req / data_req  in  1  request valid; held until the matching *_addr_ok.
- inst_wr / data_wr  in  1  1 = write, 0 = read.
- inst_size / data_size  in  2  transfer size: 0 = byte, 1 = half, 2 = word.
- inst_wstrb / data_wstrb  in  4  byte write strobes.
- inst_addr / data_addr  in  32  byte address.
- inst_wdata / data_wdata  in  32  write data.
- inst_addr_ok / data_addr_ok  out  1  request accepted (1-cycle pulse).
- inst_data_ok / data_data_ok  out  1  response complete (1-cycle pulse); read data is valid on *_rdata.
- inst_rdata / data_rdata  out  32  read data; both outputs carry m_rdata unqualified.
- m_req  out  1  downstream request valid.
- m_wr, m_size, m_wstrb, m_addr, m_wdata  out  1/2/4/32/32  latched request fields.
- m_addr_ok  in  1  downstream accepted m_req.
- m_data_ok  in  1  downstream response complete.
- m_rdata  in  32  downstream read data.

## Operation

- FSM states are IDLE, REQ and RESP. An `owner` register (0 = inst, 1 = data) and a starve counter `scnt` (3 bits) run alongside it.
- **IDLE**
  - If data_req and inst_req are both 1, data wins, unless `scnt == STARVE_LIMIT`, in which case inst wins.
  - Otherwise the single requester wins.
  - On a grant, in the same cycle: pulse the winner's *_addr_ok combinationally, latch wr/size/wstrb/addr/wdata into the m_* registers, set `owner`, and go to REQ.
  - With no request, stay in IDLE.
- **REQ**
  - m_req = 1 with the latched fields held stable.
  - On m_addr_ok, go to RESP.
  - If m_addr_ok and m_data_ok arrive in the same cycle, pulse the owner's *_data_ok and go straight to IDLE.
- **RESP**
  - m_req = 0. Wait for m_data_ok.
  - On m_data_ok, pulse `owner`'s *_data_ok for one cycle and go to IDLE.
  - m_data_ok is ignored in IDLE, and in REQ unless m_addr_ok is also 1.
- **Starve counter**
  - Increments, saturating at STARVE_LIMIT, on each data grant made while inst_req = 1.
  - Clears on any inst grant.
  - Holds otherwise.
- *_addr_ok is never asserted outside IDLE. A requester that is not granted keeps its req high and waits.

## Timing

- Reset (asynchronous): state = IDLE, owner = 0, scnt = 0, m_req = 0, m_* fields = 0, all *_addr_ok / *_data_ok = 0.
- Assertion mid-transaction abandons the transaction; no data_ok is produced.
- Grant: *_addr_ok fires in the same cycle req is seen in IDLE. m_req rises the next cycle.
- Minimum transaction takes 2 cycles (IDLE→REQ, with m_addr_ok and m_data_ok both arriving in REQ). With m_data_ok one cycle after m_addr_ok, a transaction takes 3 cycles.
- Back-to-back: a new grant can occur in the cycle after *_data_ok, because the FSM is back in IDLE.
- *_data_ok and *_rdata are combinational from m_data_ok and m_rdata. There is no extra latency.

## Structure

- Shared package holds:
  - state encoding constants `ARB_IDLE`, `ARB_REQ`, `ARB_RESP`;
  - owner constants `OWN_INST`, `OWN_DATA`;
  - size codes `SZ_B`, `SZ_H`, `SZ_W`.
- One sub-module, `arb_grant`: combinational priority plus starvation-override select, taking `inst_req`, `data_req` and `starve`, and producing `grant_valid` and `grant_owner`. The FSM, latches and counter stay in the top.

## Test plan

- Single inst read at addr 0x1C000000: inst_addr_ok in cycle 0, m_req in cycle 1, m_addr_ok in cycle 1, m_data_ok in cycle 2 with m_rdata = 0x02800C0C → inst_data_ok = 1 and inst_rdata = 0x02800C0C in cycle 2; data_data_ok stays 0.
- Simultaneous inst_req and data_req (data write, addr 0x100, wstrb 4'b0011, wdata 0xBEEF) → data_addr_ok first; m_wr = 1 and m_wstrb = 0011 held through REQ; the inst grant comes only after data_data_ok.
- data_req held high continuously with inst_req high → exactly 4 data grants, then an inst grant, then scnt = 0 and data priority resumes.
- m_addr_ok delayed 5 cycles → m_req and m_addr stay stable for all 5 cycles; no second *_addr_ok is issued.
- m_addr_ok and m_data_ok in the same cycle → the owner's data_ok pulses and the FSM is in IDLE on the next cycle.
- reset asserted in RESP → outputs go to 0 immediately; a later m_data_ok produces no *_data_ok; the next request is granted normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM state
// encoding, owner codes, transfer size codes, bus widths and the latched
// request payload.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned SIZE_W = 2;
  localparam int unsigned SCNT_W = 3;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam logic [SIZE_W-1:0] SZ_B = 2'd0;
  localparam logic [SIZE_W-1:0] SZ_H = 2'd1;
  localparam logic [SIZE_W-1:0] SZ_W = 2'd2;

  // Request fields captured on a grant and presented downstream.
  typedef struct packed {
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [STRB_W-1:0] wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_grant.sv
// Combinational grant select: data beats instruction unless the starvation
// guard is active while both are requesting.
// Ports: inst_req, data_req, starve in; grant_valid, grant_owner out.
module arb_grant
  import mem_arbiter_pkg::*;
(
  input  logic inst_req,
  input  logic data_req,
  input  logic starve,
  output logic grant_valid,
  output logic grant_owner
);

  always_comb begin
    grant_valid = inst_req | data_req;
    grant_owner = OWN_INST;
    if (data_req && !(inst_req && starve)) begin
      grant_owner = OWN_DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and load/store.
// One transaction outstanding at a time; data has priority, with a starve
// counter that forces an instruction grant after STARVE_LIMIT consecutive
// data grants taken while instruction fetch was waiting.
// Ports:
//   clk, reset                  clock, async active-high reset
//   inst_* / data_*             requester side (req/wr/size/wstrb/addr/wdata in;
//                               addr_ok/data_ok/rdata out)
//   m_req, m_wr..m_wdata        downstream request and latched fields
//   m_addr_ok, m_data_ok,
//   m_rdata                     downstream handshake and read data
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [SIZE_W-1:0] inst_size,
  input  logic [STRB_W-1:0] inst_wstrb,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,

  input  logic              data_req,
  input  logic              data_wr,
  input  logic [SIZE_W-1:0] data_size,
  input  logic [STRB_W-1:0] data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,

  output logic              m_req,
  output logic              m_wr,
  output logic [SIZE_W-1:0] m_size,
  output logic [STRB_W-1:0] m_wstrb,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_addr_ok,
  input  logic              m_data_ok,
  input  logic [DATA_W-1:0] m_rdata
);

  arb_state_e        state, next_state;
  logic              owner;
  logic [SCNT_W-1:0] scnt;
  mem_req_t          m_pkt;

  logic grant_valid, grant_owner, grant_en, done, starve;
  mem_req_t inst_pkt, data_pkt;

  assign starve   = (scnt == SCNT_W'(STARVE_LIMIT));
  assign inst_pkt = {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
  assign data_pkt = {data_wr, data_size, data_wstrb, data_addr, data_wdata};

  arb_grant u_grant (
    .inst_req    (inst_req),
    .data_req    (data_req),
    .starve      (starve),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ARB_IDLE;
    else       state <= next_state;
  end

  // Next state and handshake pulses; reset also masks the combinational
  // pulses so nothing escapes while reset is held.
  always_comb begin
    next_state   = state;
    grant_en     = 1'b0;
    done         = 1'b0;
    m_req        = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (grant_valid && !reset) begin
          grant_en     = 1'b1;
          inst_addr_ok = (grant_owner == OWN_INST);
          data_addr_ok = (grant_owner == OWN_DATA);
          next_state   = ARB_REQ;
        end
      end
      ARB_REQ: begin
        m_req = 1'b1;
        if (m_addr_ok) begin
          if (m_data_ok) begin
            done       = 1'b1;
            next_state = ARB_IDLE;
          end else begin
            next_state = ARB_RESP;
          end
        end
      end
      ARB_RESP: begin
        if (m_data_ok) begin
          done       = 1'b1;
          next_state = ARB_IDLE;
        end
      end
      default: next_state = ARB_IDLE;
    endcase
    inst_data_ok = done && !reset && (owner == OWN_INST);
    data_data_ok = done && !reset && (owner == OWN_DATA);
  end

  // Grant bookkeeping: owner, latched request fields, starve counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner <= OWN_INST;
      scnt  <= '0;
      m_pkt <= '0;
    end else if (grant_en) begin
      owner <= grant_owner;
      m_pkt <= (grant_owner == OWN_DATA) ? data_pkt : inst_pkt;
      if (grant_owner == OWN_INST) begin
        scnt <= '0;
      end else if (inst_req && !starve) begin
        scnt <= scnt + SCNT_W'(1);
      end
    end
  end

  assign m_wr    = m_pkt.wr;
  assign m_size  = m_pkt.size;
  assign m_wstrb = m_pkt.wstrb;
  assign m_addr  = m_pkt.addr;
  assign m_wdata = m_pkt.wdata;

  assign inst_rdata = m_rdata;
  assign data_rdata = m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, data_req;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;

  localparam logic [31:0] IADDR = 32'h1C00_0000;
  localparam logic [31:0] DADDR = 32'h0000_0100;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_wr      (1'b0),
    .inst_size    (SZ_W),
    .inst_wstrb   (4'hF),
    .inst_addr    (IADDR),
    .inst_wdata   (32'h0),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (1'b1),
    .data_size    (SZ_H),
    .data_wstrb   (4'b0011),
    .data_addr    (DADDR),
    .data_wdata   (32'h0000_BEEF),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .m_req        (m_req),
    .m_wr         (m_wr),
    .m_size       (m_size),
    .m_wstrb      (m_wstrb),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_addr_ok    (m_addr_ok),
    .m_data_ok    (m_data_ok),
    .m_rdata      (m_rdata)
  );

  typedef struct {
    logic        ir, dr, ma, md;
    logic [31:0] rd;
    logic        e_iaok, e_daok, e_idok, e_ddok, e_mreq;
    logic [31:0] e_maddr;
    logic        e_mwr;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(logic ir, logic dr, logic ma, logic md, logic [31:0] rd,
                              logic eia, logic eda, logic eid, logic edd, logic emr,
                              logic [31:0] ema, logic emw);
    vec_t v;
    v.ir = ir; v.dr = dr; v.ma = ma; v.md = md; v.rd = rd;
    v.e_iaok = eia; v.e_daok = eda; v.e_idok = eid; v.e_ddok = edd;
    v.e_mreq = emr; v.e_maddr = ema; v.e_mwr = emw;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Apply inputs mid-cycle and let combinational outputs settle.
  task automatic drive(logic ir, logic dr, logic ma, logic md, logic [31:0] rd);
    @(negedge clk);
    inst_req = ir; data_req = dr; m_addr_ok = ma; m_data_ok = md; m_rdata = rd;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    inst_req = 1'b1; data_req = 1'b1;
    m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h0;

    // Reset state, with requests present: no pulses, fields cleared
    @(negedge clk); #1;
    chk("rst iaok", 32'(inst_addr_ok), 32'd0);
    chk("rst daok", 32'(data_addr_ok), 32'd0);
    chk("rst idok", 32'(inst_data_ok), 32'd0);
    chk("rst ddok", 32'(data_data_ok), 32'd0);
    chk("rst mreq", 32'(m_req), 32'd0);
    chk("rst maddr", m_addr, 32'd0);
    chk("rst mwstrb", 32'(m_wstrb), 32'd0);
    @(negedge clk);
    reset = 1'b0; inst_req = 1'b0; data_req = 1'b0; m_data_ok = 1'b0;

    // Vector table: single inst read, simultaneous requests, same-cycle
    // addr/data ok, data_ok ignored in IDLE and in REQ without addr_ok.
    tbl[0]  = mk(1,0,0,0,32'h0,         1,0,0,0,0,32'h0,0);
    tbl[1]  = mk(0,0,1,0,32'h0,         0,0,0,0,1,IADDR,0);
    tbl[2]  = mk(0,0,0,1,32'h02800C0C,  0,0,1,0,0,IADDR,0);
    tbl[3]  = mk(1,1,0,0,32'h0,         0,1,0,0,0,IADDR,0);
    tbl[4]  = mk(1,0,0,0,32'h0,         0,0,0,0,1,DADDR,1);
    tbl[5]  = mk(1,0,1,0,32'h0,         0,0,0,0,1,DADDR,1);
    tbl[6]  = mk(1,0,0,1,32'h12345678,  0,0,0,1,0,DADDR,1);
    tbl[7]  = mk(1,0,0,0,32'h0,         1,0,0,0,0,DADDR,1);
    tbl[8]  = mk(0,0,1,1,32'hAAAA5555,  0,0,1,0,1,IADDR,0);
    tbl[9]  = mk(0,0,0,1,32'h0,         0,0,0,0,0,IADDR,0);
    tbl[10] = mk(0,1,0,0,32'h0,         0,1,0,0,0,IADDR,0);
    tbl[11] = mk(0,0,0,1,32'h0,         0,0,0,0,1,DADDR,1);
    tbl[12] = mk(0,0,1,0,32'h0,         0,0,0,0,1,DADDR,1);
    tbl[13] = mk(0,0,0,1,32'hCAFEF00D,  0,0,0,1,0,DADDR,1);

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].ir, tbl[i].dr, tbl[i].ma, tbl[i].md, tbl[i].rd);
      chk($sformatf("v%0d iaok", i), 32'(inst_addr_ok), 32'(tbl[i].e_iaok));
      chk($sformatf("v%0d daok", i), 32'(data_addr_ok), 32'(tbl[i].e_daok));
      chk($sformatf("v%0d idok", i), 32'(inst_data_ok), 32'(tbl[i].e_idok));
      chk($sformatf("v%0d ddok", i), 32'(data_data_ok), 32'(tbl[i].e_ddok));
      chk($sformatf("v%0d mreq", i), 32'(m_req), 32'(tbl[i].e_mreq));
      chk($sformatf("v%0d maddr", i), m_addr, tbl[i].e_maddr);
      chk($sformatf("v%0d mwr", i), 32'(m_wr), 32'(tbl[i].e_mwr));
      chk($sformatf("v%0d irdata", i), inst_rdata, tbl[i].rd);
      chk($sformatf("v%0d drdata", i), data_rdata, tbl[i].rd);
    end

    // Starvation: both held high -> D D D D I D
    for (int g = 0; g < 6; g++) begin
      logic exp_inst;
      exp_inst = (g == 4);
      drive(1, 1, 0, 0, 32'h0);
      chk($sformatf("stv%0d iaok", g), 32'(inst_addr_ok), 32'(exp_inst));
      chk($sformatf("stv%0d daok", g), 32'(data_addr_ok), 32'(!exp_inst));
      drive(1, 1, 1, 1, 32'h5A5A0000 + 32'(g));
      chk($sformatf("stv%0d mreq", g), 32'(m_req), 32'd1);
      chk($sformatf("stv%0d maddr", g), m_addr, exp_inst ? IADDR : DADDR);
      chk($sformatf("stv%0d busy aok", g), 32'(inst_addr_ok | data_addr_ok), 32'd0);
      chk($sformatf("stv%0d idok", g), 32'(inst_data_ok), 32'(exp_inst));
      chk($sformatf("stv%0d ddok", g), 32'(data_data_ok), 32'(!exp_inst));
    end

    // m_addr_ok delayed 5 cycles while inst waits
    drive(0, 1, 0, 0, 32'h0);
    chk("dly grant", 32'(data_addr_ok), 32'd1);
    for (int c = 0; c < 5; c++) begin
      drive(1, 0, 0, 0, 32'h0);
      chk($sformatf("dly%0d mreq", c), 32'(m_req), 32'd1);
      chk($sformatf("dly%0d maddr", c), m_addr, DADDR);
      chk($sformatf("dly%0d mwstrb", c), 32'(m_wstrb), 32'h3);
      chk($sformatf("dly%0d mwdata", c), m_wdata, 32'h0000_BEEF);
      chk($sformatf("dly%0d aok", c), 32'(inst_addr_ok | data_addr_ok), 32'd0);
    end
    drive(0, 0, 1, 0, 32'h0);
    chk("dly accept mreq", 32'(m_req), 32'd1);
    drive(0, 0, 0, 1, 32'h0);
    chk("dly ddok", 32'(data_data_ok), 32'd1);

    // Reset while in RESP
    drive(1, 0, 0, 0, 32'h0);
    chk("rr grant", 32'(inst_addr_ok), 32'd1);
    drive(0, 0, 1, 0, 32'h0);
    @(negedge clk);
    reset = 1'b1; m_addr_ok = 1'b0; m_data_ok = 1'b1;
    #1;
    chk("rr idok", 32'(inst_data_ok), 32'd0);
    chk("rr mreq", 32'(m_req), 32'd0);
    chk("rr maddr", m_addr, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rr late idok", 32'(inst_data_ok), 32'd0);
    chk("rr late ddok", 32'(data_data_ok), 32'd0);
    drive(1, 0, 0, 0, 32'h0);
    chk("rr regrant", 32'(inst_addr_ok), 32'd1);
    drive(0, 0, 1, 1, 32'h0BADF00D);
    chk("rr mreq2", 32'(m_req), 32'd1);
    chk("rr maddr2", m_addr, IADDR);
    chk("rr idok2", 32'(inst_data_ok), 32'd1);
    chk("rr irdata2", inst_rdata, 32'h0BADF00D);
    drive(0, 0, 0, 0, 32'h0);
    chk("rr idle mreq", 32'(m_req), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
